fpcvt_pipe: RTL and testbench
=============================

FPCVT_PIPE -- requirements
Module: fpcvt_pipe

Interface
REQ-001 SHALL have parameter DW, default 12: input two's-complement width, DW >= MW+2.
REQ-002 SHALL have parameter EW, default 3: exponent width; EMAX = 2^EW-1.
REQ-003 SHALL have parameter MW, default 4: significand width, MW >= 2.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: D, rnd_mode valid this cycle.
REQ-007 SHALL have port in_ready, output, 1: pipeline accepts a sample this cycle.
REQ-008 SHALL have port D, input, DW: two's-complement sample.
REQ-009 SHALL have port rnd_mode, input, 1: 0 = round-half-up, 1 = truncate; travels with its sample.
REQ-010 SHALL have port out_valid, output, 1: S/E/F/ovf hold a result.
REQ-011 SHALL have port out_ready, input, 1: consumer takes the result this cycle.
REQ-012 SHALL have ports S (output, 1, sign), E (output, EW, exponent) and F (output, MW, significand); the value is (-1)^S * F * 2^E.
REQ-013 SHALL have port ovf, output, 1: result saturated.

Function
REQ-014 SHALL be a 3-stage pipeline:
- st1: sign/magnitude; S = D[DW-1]; mag = |D| as an unsigned DW-bit value.
- st2: leading-one position p, F extraction, round bit.
- st3: rounding and saturation.
REQ-015 SHALL accept a sample on in_valid & in_ready, and the transfer SHALL complete on out_valid & out_ready.
REQ-016 SHALL drive in_ready = !out_valid | out_ready; all stages advance together when in_ready=1 and hold otherwise.
REQ-017 SHALL have latency exactly 3 cycles from acceptance to out_valid when unstalled, with throughput of 1 sample per cycle.
REQ-018 SHALL hold S/E/F/ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL let idle cycles propagate as bubbles: a stage's valid bit clears when it advances without new data.
REQ-020 SHALL, when mag=0, produce E=0, F=0, ovf=0.
REQ-021 SHALL, when p <= MW-1, produce E=0, F=mag[MW-1:0] with no rounding.
REQ-022 SHALL, when p >= MW:
- raw exponent e = p-MW+1;
- F = mag[p:p-MW+1];
- round bit r = mag[p-MW].
REQ-023 SHALL, when rnd_mode=0 and r=1, increment F; if F overflows (all ones +1), set F = 1 followed by MW-1 zeros and e = e+1.
REQ-024 SHALL ignore r when rnd_mode=1.
REQ-025 SHALL, when the final e > EMAX, saturate to E=EMAX, F=all ones, ovf=1; otherwise E=e, ovf=0.
REQ-026 SHALL treat D = most-negative (magnitude 2^(DW-1)) as an ordinary magnitude and saturate it per REQ-025 for the default parameters.
REQ-027 SHALL compute S from D for every input including zero, so D=0 gives S=0.
REQ-028 SHALL size all internal widths from DW/EW/MW, with no truncation of p or e before the saturation compare.

Reset
REQ-029 SHALL, on clk edge with rst_n=0, clear all stage valid bits, out_valid=0, S=0, E=0, F=0, ovf=0.
REQ-030 SHALL drop samples in flight when reset is asserted mid-operation and produce no output for them.
REQ-031 SHALL hold in_ready=1 during and after reset.
REQ-032 SHALL accept a sample on the first cycle with rst_n=1.

Verification (defaults DW=12, EW=3, MW=4, rnd_mode=0 unless stated)
REQ-033 SHALL cover D=0x000 -> S=0 E=0 F=0000 ovf=0; and D=0x00D -> S=0 E=0 F=1101, 3 cycles after accept.
REQ-034 SHALL cover D=0x07D -> S=0 E=4 F=1000 (mantissa round carry); same D with rnd_mode=1 -> E=3 F=1111; D=0xF83 -> S=1 E=4 F=1000.
REQ-035 SHALL cover D=0x7FF -> E=7 F=1111 ovf=1 (round-driven saturation); and D=0x800 -> S=1 E=7 F=1111 ovf=1.
REQ-036 SHALL cover 8 back-to-back samples with out_ready=1 -> 8 consecutive out_valid cycles in order; then out_ready=0 for 4 cycles -> in_ready=0, outputs frozen, no loss or duplication on release.
REQ-037 SHALL cover rst_n=0 for 1 cycle with 3 samples in flight -> out_valid=0 next cycle, dropped samples never appear, a new sample appears 3 cycles after its accept.
REQ-038 SHALL cover random D with random in_valid/out_ready against a reference model of REQ-020..REQ-027, plus one alternate parameter set (DW=16, EW=4, MW=5).

Source files
------------

// File: rtl/fpcvt_pipe.sv
// Three-stage two's-complement to small floating-point converter (sign, exponent, significand).
// Round-half-up or truncate per sample, saturating at the largest exponent, valid/ready flow control.
module fpcvt_pipe #(
    parameter int DW = 12,
    parameter int EW = 3,
    parameter int MW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] D,
    input  logic          rnd_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          S,
    output logic [EW-1:0] E,
    output logic [MW-1:0] F,
    output logic          ovf
);

    localparam int PW = $clog2(DW);
    // Exponent carried wide enough that the post-round increment never wraps before the compare.
    localparam int XW = ((PW > EW) ? PW : EW) + 2;
    localparam logic [XW-1:0] EMAX = XW'((1 << EW) - 1);

    logic          v1;
    logic          s1_s;
    logic          s1_rm;
    logic [DW-1:0] s1_mag;

    logic          v2;
    logic          s2_s;
    logic          s2_r;
    logic [MW-1:0] s2_f;
    logic [XW-1:0] s2_e;

    logic [PW-1:0] lead_pos;
    logic [PW-1:0] shamt;
    logic [PW-1:0] shamt_m1;
    logic [MW-1:0] f_nx;
    logic          r_nx;
    logic [XW-1:0] e_nx;

    logic [MW:0]   f_sum;
    logic [MW-1:0] f_fin;
    logic [XW-1:0] e_fin;

    // Reset forces ready so upstream never sees a stall while the pipe is being flushed.
    assign in_ready = !rst_n || !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            s1_s   <= 1'b0;
            s1_rm  <= 1'b0;
            s1_mag <= '0;
        end else if (in_ready) begin
            v1     <= in_valid;
            s1_s   <= D[DW-1];
            s1_rm  <= rnd_mode;
            s1_mag <= D[DW-1] ? ({DW{1'b0}} - D) : D;
        end
    end

    always_comb begin
        lead_pos = '0;
        for (int i = 0; i < DW; i++) begin
            if (s1_mag[i]) lead_pos = PW'(i);
        end
        shamt    = lead_pos - PW'(MW - 1);
        shamt_m1 = shamt - PW'(1);
        if (lead_pos >= PW'(MW)) begin
            f_nx = s1_mag[shamt +: MW];
            r_nx = s1_mag[shamt_m1] & ~s1_rm;
            e_nx = XW'(shamt);
        end else begin
            f_nx = s1_mag[MW-1:0];
            r_nx = 1'b0;
            e_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            s2_s <= 1'b0;
            s2_r <= 1'b0;
            s2_f <= '0;
            s2_e <= '0;
        end else if (in_ready) begin
            v2   <= v1;
            s2_s <= s1_s;
            s2_r <= r_nx;
            s2_f <= f_nx;
            s2_e <= e_nx;
        end
    end

    always_comb begin
        f_sum = {1'b0, s2_f} + {{MW{1'b0}}, s2_r};
        if (f_sum[MW]) begin
            f_fin = {1'b1, {(MW-1){1'b0}}};
            e_fin = s2_e + XW'(1);
        end else begin
            f_fin = f_sum[MW-1:0];
            e_fin = s2_e;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            S         <= 1'b0;
            E         <= '0;
            F         <= '0;
            ovf       <= 1'b0;
        end else if (in_ready) begin
            out_valid <= v2;
            S         <= s2_s;
            if (e_fin > EMAX) begin
                E   <= '1;
                F   <= '1;
                ovf <= 1'b1;
            end else begin
                E   <= e_fin[EW-1:0];
                F   <= f_fin;
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Directed and randomized checks of fpcvt_pipe, default parameters plus a DW=16/EW=4/MW=5 instance.
module tb_fpcvt_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, rnd_mode, out_valid, out_ready, S, ovf;
    logic [11:0] D;
    logic [2:0]  E;
    logic [3:0]  F;

    logic        b_in_valid, b_in_ready, b_rnd_mode, b_out_valid, b_out_ready, b_S, b_ovf;
    logic [15:0] b_D;
    logic [3:0]  b_E;
    logic [4:0]  b_F;

    int          n_pass = 0;
    int          n_fail = 0;
    int          pops_a = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    always #5 clk = ~clk;

    fpcvt_pipe dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .D(D),
        .rnd_mode(rnd_mode), .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .E(E), .F(F), .ovf(ovf)
    );

    fpcvt_pipe #(.DW(16), .EW(4), .MW(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .D(b_D),
        .rnd_mode(b_rnd_mode), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .S(b_S), .E(b_E), .F(b_F), .ovf(b_ovf)
    );

    function automatic logic [31:0] pk(logic s, int e, int f, logic o);
        return {6'd0, o, s, 8'(e), 16'(f)};
    endfunction

    // Behavioural reference for any parameter set up to 16-bit inputs.
    function automatic logic [31:0] model(int dw, int ew, int mw, logic [31:0] d, logic rm);
        logic   s;
        logic   o;
        longint raw, mag, f, r;
        int     p, e;
        s   = d[dw-1];
        raw = longint'(d) & ((longint'(1) << dw) - 1);
        mag = s ? ((longint'(1) << dw) - raw) : raw;
        p = -1;
        for (int i = 0; i < dw; i++) if (((mag >> i) & 1) == 1) p = i;
        e = 0;
        f = mag;
        o = 1'b0;
        if (p >= mw) begin
            e = p - mw + 1;
            f = mag >> e;
            r = (mag >> (e - 1)) & 1;
            if (r == 1 && !rm) f = f + 1;
            if (f == (longint'(1) << mw)) begin
                f = longint'(1) << (mw - 1);
                e = e + 1;
            end
        end
        if (e > (1 << ew) - 1) begin
            e = (1 << ew) - 1;
            f = (longint'(1) << mw) - 1;
            o = 1'b1;
        end
        return pk(s, e, int'(f), o);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic eval_a();
        if (out_valid && out_ready) begin
            chk("a_sb_nonempty", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
                chk("a_result", pk(S, int'(E), int'(F), ovf), q_a.pop_front());
                pops_a++;
            end
        end
        if (in_valid && in_ready) q_a.push_back(model(12, 3, 4, 32'(D), rnd_mode));
    endtask

    task automatic eval_b();
        if (b_out_valid && b_out_ready) begin
            chk("b_sb_nonempty", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) chk("b_result", pk(b_S, int'(b_E), int'(b_F), b_ovf), q_b.pop_front());
        end
        if (b_in_valid && b_in_ready) q_b.push_back(model(16, 4, 5, 32'(b_D), b_rnd_mode));
    endtask

    task automatic drive_a(logic iv, logic [11:0] d, logic rm, logic ordy);
        in_valid  = iv;
        D         = d;
        rnd_mode  = rm;
        out_ready = ordy;
        #1;
        eval_a();
    endtask

    // One isolated sample: checks acceptance, 3-cycle latency and the hand-computed result.
    task automatic single(string tag, logic [11:0] d, logic rm, logic [31:0] exp);
        int lat;
        in_valid  = 1'b1;
        D         = d;
        rnd_mode  = rm;
        out_ready = 1'b1;
        #1;
        chk({tag, "_accept"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk(tag, pk(S, int'(E), int'(F), ovf), exp);
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        D           = '0;
        rnd_mode    = 1'b0;
        out_ready   = 1'b1;
        b_in_valid  = 1'b0;
        b_D         = '0;
        b_rnd_mode  = 1'b0;
        b_out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", pk(S, int'(E), int'(F), ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);

        rst_n = 1'b1;
        single("zero", 12'h000, 1'b0, pk(0, 0, 0, 0));
        single("small_0d", 12'h00D, 1'b0, pk(0, 0, 13, 0));
        single("rnd_carry", 12'h07D, 1'b0, pk(0, 4, 8, 0));
        single("trunc_07d", 12'h07D, 1'b1, pk(0, 3, 15, 0));
        single("neg_f83", 12'hF83, 1'b0, pk(1, 4, 8, 0));
        single("sat_7ff", 12'h7FF, 1'b0, pk(0, 7, 15, 1));
        single("most_neg", 12'h800, 1'b0, pk(1, 7, 15, 1));
        single("p_eq_mw", 12'h010, 1'b0, pk(0, 1, 8, 0));
        single("no_round", 12'h018, 1'b0, pk(0, 1, 12, 0));
        single("round_up", 12'h019, 1'b0, pk(0, 1, 13, 0));
        single("minus_one", 12'hFFF, 1'b0, pk(1, 0, 1, 0));
        single("emax_edge", 12'h400, 1'b0, pk(0, 7, 8, 0));
        single("sat_7c0", 12'h7C0, 1'b0, pk(0, 7, 15, 1));
        single("trunc_7c0", 12'h7C0, 1'b1, pk(0, 7, 15, 0));

        // Eight back-to-back samples must emerge on eight consecutive cycles.
        begin
            int p0;
            p0 = pops_a;
            for (int i = 0; i < 8; i++) begin
                drive_a(1'b1, 12'(i * 300 + 5), 1'(i % 2), 1'b1);
                tick();
            end
            for (int i = 0; i < 3; i++) begin
                drive_a(1'b0, 12'h000, 1'b0, 1'b1);
                tick();
            end
            chk("b2b_count", 32'(pops_a - p0), 32'd8);
            drive_a(1'b0, 12'h000, 1'b0, 1'b1);
            chk("b2b_drained", 32'(out_valid), 32'd0);
            tick();
        end

        // Consumer stall: pipe must freeze and release without loss or duplication.
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 12'(12'h0A5 + i * 12'h111), 1'b0, 1'b1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 12'h6C3, 1'b0, 1'b0);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", pk(S, int'(E), int'(F), ovf), q_a[0]);
            tick();
        end
        begin
            int guard;
            guard = 0;
            while (q_a.size() != 0 && guard < 20) begin
                drive_a(1'b0, 12'h000, 1'b0, 1'b1);
                tick();
                guard++;
            end
            chk("stall_drain", 32'(q_a.size()), 32'd0);
            for (int i = 0; i < 3; i++) begin
                drive_a(1'b0, 12'h000, 1'b0, 1'b1);
                tick();
            end
            chk("stall_no_dup", 32'(out_valid), 32'd0);
        end

        // Reset with three samples in flight.
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 12'(12'h321 + i * 12'h40), 1'b0, 1'b1);
            tick();
        end
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        tick();
        q_a.delete();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_outputs", pk(S, int'(E), int'(F), ovf), 32'd0);
        rst_n = 1'b1;
        single("post_rst", 12'h05A, 1'b0, pk(0, 3, 11, 0));
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b0, 12'h000, 1'b0, 1'b1);
            tick();
        end

        // Random traffic on both parameter sets against the reference model.
        for (int n = 0; n < 600; n++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            D           = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 31)) : 12'($urandom);
            rnd_mode    = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_D         = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 63)) : 16'($urandom);
            b_rnd_mode  = 1'($urandom_range(0, 1));
            b_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            eval_a();
            eval_b();
            tick();
        end
        in_valid    = 1'b0;
        b_in_valid  = 1'b0;
        out_ready   = 1'b1;
        b_out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            #1;
            eval_a();
            eval_b();
            tick();
        end
        chk("rand_a_drain", 32'(q_a.size()), 32'd0);
        chk("rand_b_drain", 32'(q_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
